// File: rtl/serial_adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : serial_adder_pkg                                          |
// | Purpose  : Shared state encoding and mode codes for the bit-serial   |
// |            adder/subtractor/accumulator.                             |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package serial_adder_pkg;

  // Controller states; explicit 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operation select codes presented on the mode input.
  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_ACC = 2'b10;
  localparam logic [1:0] MODE_CLR = 2'b11;

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/fa_cell.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fa_cell                                                   |
// | Purpose  : Single-bit combinational full adder; the one arithmetic   |
// |            cell that the serial datapath reuses every clock.         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum is the three-way parity, carry is the majority of the inputs.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule : fa_cell
`default_nettype wire

// File: rtl/serial_adder_acc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : serial_adder_acc                                          |
// | Purpose  : WIDTH-bit bit-serial add / subtract / accumulate unit.    |
// |            One bit per clock, LSB first, through a single full-adder |
// |            cell and a carry flop, with a start/busy/done handshake.  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module serial_adder_acc
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_sum;      // sum bits produced so far, newest at the MSB
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_result;
  logic             r_c;
  logic             r_carry_out;
  logic             r_overflow;
  logic             r_is_acc;
  logic [CNT_W-1:0] r_cnt;

  logic             w_s;
  logic             w_cout;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_full;

  fa_cell u_fa (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_c),
    .s    (w_s),
    .cout (w_cout)
  );

  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  // On the final bit edge this is the complete sum; otherwise its upper
  // WIDTH-1 bits are the next contents of the sum shift register.
  assign w_sum_full = {w_s, r_sum};

  // Next-state and handshake outputs; start is only honoured outside RUN.
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = (mode == MODE_CLR) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) w_next = (mode == MODE_CLR) ? DONE : RUN;
        else       w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // State register; a low enable freezes the controller.
  always_ff @(posedge clk) begin
    if (rst)      r_state <= IDLE;
    else if (ena) r_state <= w_next;
  end

  // Operand load, per-bit shifting and result/flag capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_acc       <= '0;
      r_result    <= '0;
      r_c         <= 1'b0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_is_acc    <= 1'b0;
      r_cnt       <= '0;
    end else if (ena) begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            if (mode == MODE_CLR) begin
              r_acc       <= '0;
              r_result    <= '0;
              r_carry_out <= 1'b0;
              r_overflow  <= 1'b0;
            end else begin
              // Accumulate adds op_a onto the stored accumulator; subtract
              // is A + ~B + 1 with the +1 injected through the carry flop.
              r_a      <= (mode == MODE_ACC) ? r_acc : op_a;
              r_b      <= (mode == MODE_SUB) ? ~op_b :
                          (mode == MODE_ACC) ? op_a  : op_b;
              r_c      <= (mode == MODE_SUB);
              r_is_acc <= (mode == MODE_ACC);
              r_cnt    <= '0;
            end
          end
        end
        RUN: begin
          r_sum <= w_sum_full[WIDTH-1:1];
          r_c   <= w_cout;
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            // On this edge a0/b0 are the operand sign bits as seen by the
            // adder (inverted-B MSB for subtract).
            r_result    <= w_sum_full;
            r_carry_out <= w_cout;
            r_overflow  <= (r_a[0] == r_b[0]) && (w_s != r_a[0]);
            if (r_is_acc) r_acc <= w_sum_full;
          end
        end
        default: ;
      endcase
    end
  end

  assign result    = r_result;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;

endmodule : serial_adder_acc
`default_nettype wire

// File: tb/tb_serial_adder_acc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_serial_adder_acc                                       |
// | Purpose  : Directed self-checking bench for serial_adder_acc at      |
// |            WIDTH=8 plus a WIDTH=16 instance for the wide carry case. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_serial_adder_acc;

  localparam logic [1:0] M_ADD = 2'b00;
  localparam logic [1:0] M_SUB = 2'b01;
  localparam logic [1:0] M_ACC = 2'b10;
  localparam logic [1:0] M_CLR = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        start;
  logic [1:0]  mode;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic        busy;
  logic        done;
  logic [7:0]  result;
  logic        carry_out;
  logic        overflow;

  logic        start16;
  logic [1:0]  mode16;
  logic [15:0] op_a16;
  logic [15:0] op_b16;
  logic        busy16;
  logic        done16;
  logic [15:0] result16;
  logic        carry16;
  logic        ovf16;

  int total = 0;
  int bad   = 0;

  serial_adder_acc #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .start     (start),
    .mode      (mode),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  serial_adder_acc #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .start     (start16),
    .mode      (mode16),
    .op_a      (op_a16),
    .op_b      (op_b16),
    .busy      (busy16),
    .done      (done16),
    .result    (result16),
    .carry_out (carry16),
    .overflow  (ovf16)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge, then wait for done. n = edges from the start
  // edge to the edge after which done is seen (-1 on timeout); bcnt = edges
  // after which busy was high; b0/d0 = busy/done right after the start edge.
  task automatic run_op(input logic [1:0] m, input logic [7:0] a,
                        input logic [7:0] b, output int n, output int bcnt,
                        output logic b0, output logic d0);
    mode  = m;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    b0    = busy;
    d0    = done;
    n     = 0;
    bcnt  = busy ? 1 : 0;
    while (!done && n < 40) begin
      tick();
      n++;
      if (busy) bcnt++;
    end
    if (!done) n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if ({busy, done, result, carry_out, overflow} !== 11'b0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b result=%h c=%b ov=%b want all 0",
               busy, done, result, carry_out, overflow);
    end
  endtask

  task automatic test_add();
    int n, bc;
    logic b0, d0;
    run_op(M_ADD, 8'h5A, 8'h3C, n, bc, b0, d0);
    total++;
    if (n !== 8) begin bad++; $display("FAIL add_latency: got %0d want 8", n); end
    total++;
    if (bc !== 8) begin bad++; $display("FAIL add_busy_cycles: got %0d want 8", bc); end
    total++;
    if ({result, carry_out, overflow} !== {8'h96, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL add_5A_3C: got %h c=%b ov=%b want 96 c=0 ov=1", result, carry_out, overflow);
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== 8'h96) begin
      bad++;
      $display("FAIL add_idle_hold: got done=%b busy=%b result=%h want 0 0 96", done, busy, result);
    end
  endtask

  task automatic test_sub();
    int n, bc;
    logic b0, d0;
    run_op(M_SUB, 8'h10, 8'h20, n, bc, b0, d0);
    total++;
    if ({result, carry_out, overflow} !== {8'hF0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL sub_10_20: got %h c=%b ov=%b want F0 c=0 ov=0", result, carry_out, overflow);
    end
    run_op(M_SUB, 8'h80, 8'h01, n, bc, b0, d0);
    total++;
    if ({result, carry_out, overflow} !== {8'h7F, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL sub_80_01: got %h c=%b ov=%b want 7F c=1 ov=1", result, carry_out, overflow);
    end
    total++;
    if (n !== 8) begin bad++; $display("FAIL sub_latency: got %0d want 8", n); end
  endtask

  task automatic test_back_to_back();
    int n, bc;
    logic b0, d0;
    run_op(M_ADD, 8'hFF, 8'h01, n, bc, b0, d0);
    total++;
    if ({result, carry_out, overflow} !== {8'h00, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL add_FF_01: got %h c=%b ov=%b want 00 c=1 ov=0", result, carry_out, overflow);
    end
    // Issued straight from DONE, with no idle edge in between.
    run_op(M_ADD, 8'h01, 8'h02, n, bc, b0, d0);
    total++;
    if (b0 !== 1'b1 || d0 !== 1'b0) begin
      bad++;
      $display("FAIL b2b_no_bubble: got busy=%b done=%b want 1 0", b0, d0);
    end
    total++;
    if (n !== 8 || result !== 8'h03) begin
      bad++;
      $display("FAIL b2b_second_op: got n=%0d result=%h want 8 03", n, result);
    end
  endtask

  task automatic test_acc();
    int n, bc;
    logic b0, d0;
    logic [7:0] exp_r [3] = '{8'h40, 8'h80, 8'hC0};
    logic       exp_v [3] = '{1'b0, 1'b1, 1'b0};
    run_op(M_CLR, 8'hAA, 8'h55, n, bc, b0, d0);
    for (int i = 0; i < 3; i++) begin
      run_op(M_ACC, 8'h40, 8'hFF, n, bc, b0, d0);
      total++;
      if (result !== exp_r[i] || overflow !== exp_v[i] || carry_out !== 1'b0) begin
        bad++;
        $display("FAIL acc_step%0d: got %h c=%b ov=%b want %h c=0 ov=%b",
                 i, result, carry_out, overflow, exp_r[i], exp_v[i]);
      end
    end
    run_op(M_CLR, 8'h12, 8'h34, n, bc, b0, d0);
    total++;
    if (n !== 0 || bc !== 0 || result !== 8'h00 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL clear: got n=%0d busy_cycles=%0d result=%h ov=%b want 0 0 00 0",
               n, bc, result, overflow);
    end
    // Accumulator must restart from zero after the clear.
    run_op(M_ACC, 8'h11, 8'h00, n, bc, b0, d0);
    total++;
    if (result !== 8'h11) begin
      bad++;
      $display("FAIL acc_after_clear: got %h want 11", result);
    end
  endtask

  task automatic test_stall_and_ignore();
    int n;
    mode  = M_ADD;
    op_a  = 8'h5A;
    op_b  = 8'h3C;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    // Restart attempt and operand changes while running must be ignored.
    start = 1'b1;
    mode  = M_SUB;
    op_a  = 8'hFF;
    op_b  = 8'h01;
    tick();
    start = 1'b0;
    ena   = 1'b0;
    tick();
    tick();
    tick();
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL stall_frozen: got busy=%b done=%b want 1 0", busy, done);
    end
    ena = 1'b1;
    n   = 6;
    while (!done && n < 60) begin
      tick();
      n++;
    end
    total++;
    if (n !== 11) begin bad++; $display("FAIL stall_latency: got %0d want 11", n); end
    total++;
    if ({result, carry_out, overflow} !== {8'h96, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL stall_result: got %h c=%b ov=%b want 96 c=0 ov=1", result, carry_out, overflow);
    end
    ena = 1'b0;
    tick();
    tick();
    total++;
    if (done !== 1'b1 || result !== 8'h96) begin
      bad++;
      $display("FAIL done_hold_disabled: got done=%b result=%h want 1 96", done, result);
    end
    ena = 1'b1;
    tick();
  endtask

  task automatic test_rst_mid();
    int n, bc;
    logic b0, d0;
    run_op(M_ACC, 8'h22, 8'h00, n, bc, b0, d0);
    mode  = M_ADD;
    op_a  = 8'h7F;
    op_b  = 8'h7F;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({busy, done, result, carry_out, overflow} !== 11'b0) begin
      bad++;
      $display("FAIL rst_mid_outputs: got busy=%b done=%b result=%h c=%b ov=%b want all 0",
               busy, done, result, carry_out, overflow);
    end
    run_op(M_ACC, 8'h05, 8'h00, n, bc, b0, d0);
    total++;
    if (result !== 8'h05 || n !== 8) begin
      bad++;
      $display("FAIL rst_mid_acc_cleared: got result=%h n=%0d want 05 8", result, n);
    end
  endtask

  task automatic test_w16();
    int n;
    mode16  = M_ADD;
    op_a16  = 16'hFFFF;
    op_b16  = 16'h0001;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    n = 0;
    while (!done16 && n < 60) begin
      tick();
      n++;
    end
    total++;
    if (n !== 16) begin bad++; $display("FAIL w16_latency: got %0d want 16", n); end
    total++;
    if ({result16, carry16, ovf16} !== {16'h0000, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL w16_add: got %h c=%b ov=%b want 0000 c=1 ov=0", result16, carry16, ovf16);
    end
  endtask

  initial begin
    rst     = 1'b1;
    ena     = 1'b1;
    start   = 1'b0;
    mode    = 2'b00;
    op_a    = '0;
    op_b    = '0;
    start16 = 1'b0;
    mode16  = 2'b00;
    op_a16  = '0;
    op_b16  = '0;
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_acc();
    test_stall_and_ignore();
    test_rst_mid();
    test_w16();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_serial_adder_acc
`default_nettype wire

// File: doc/serial_adder_acc.md
Name: serial_adder_acc

Overview:
- Parametrised successor to the single-bit half-adder tile: a WIDTH-bit bit-serial adder/subtractor/accumulator.
- Processes one bit per clock, LSB first, through a single full-adder cell and a carry flop.
- Uses a start/busy/done handshake.
- Sits behind the tile's ui_in/uio_in/uo_out mapping in the top-level wrapper.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, synchronous, active-high.
- ena  in  1  tile enable; low freezes all state.
- start  in  1  request; sampled only when ena=1 and state is IDLE or DONE.
- mode  in  2  00 add a+b, 01 sub a-b, 10 accumulate acc+a, 11 clear acc.
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B (ignored in modes 10/11).
- busy  out  1  high while bits are being processed.
- done  out  1  one-cycle pulse; result/flags valid.
- result  out  WIDTH  last result (for modes 10/11, the accumulator value).
- carry_out  out  1  final carry (sub: 1 = no borrow).
- overflow  out  1  signed two's-complement overflow of last op.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, busy=0, done=0, result=0, carry_out=0, overflow=0, acc=0, bit counter=0. Reset has priority over ena and aborts any operation mid-run. Accumulator is cleared and the partial result is discarded.
- ena=0: every register holds, including done. start is not sampled.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE with start=1, mode 00/01/10:
  - Latch the A shift register with op_a.
  - Latch the B shift register with op_b, ~op_b (sub), or op_a (accumulate, with A loaded from acc).
  - Carry flop = 1 for sub, else 0.
  - Counter=0; go to RUN.
- IDLE/DONE with start=1, mode 11: acc<=0, result<=0, carry_out<=0, overflow<=0; go to DONE. No RUN phase.
- RUN, each edge:
  - sum = a0^b0^c, shifted into the MSB of the result shift register.
  - c <= majority(a0,b0,c).
  - A/B shift right; counter++.
  - Sign bits of A and B are captured when counter==WIDTH-1.
  - On the edge with counter==WIDTH-1: go to DONE.
  - At that edge, result <= assembled sum and carry_out <= final carry.
  - overflow <= (sa==sb)&&(sum_msb!=sa), where sa/sb are the operand sign bits as fed to the adder; for sub, sb is the inverted-B MSB.
  - Mode 10: acc <= sum.
- Latency: start sampled at edge 0; busy=1 after edges 0..WIDTH-1; done=1 and busy=0 after edge WIDTH. Total WIDTH clocks from start to done.
- DONE lasts one cycle: done=1. Next edge goes to IDLE (done=0) unless start=1, in which case a new op is accepted (back-to-back, no bubble).
- start during RUN is ignored. Operand/mode changes during RUN have no effect; they are latched at start.
- result/carry_out/overflow hold between operations until the next done or reset.
- Arithmetic is modulo 2^WIDTH. Counter width is clog2(WIDTH).

Decomposition:
- Package serial_adder_pkg: state enum (IDLE, RUN, DONE) and mode constants (MODE_ADD, MODE_SUB, MODE_ACC, MODE_CLR).
- One sub-module: fa_cell, a combinational full adder (a, b, cin -> s, cout), the 1-bit cell generalised from the half-adder tile.
- Carry flop, shift registers and FSM live in serial_adder_acc.

Test Plan (WIDTH=8 unless stated):
- Reset then add 0x5A+0x3C -> done pulses exactly 8 clocks after start edge; result=0x96, carry_out=0, overflow=1; busy high 8 cycles.
- Sub 0x10-0x20 -> result=0xF0, carry_out=0, overflow=0. Sub 0x80-0x01 -> result=0x7F, carry_out=1, overflow=1.
- Add 0xFF+0x01 -> result=0x00, carry_out=1, overflow=0. Hold start high in DONE -> second op begins with no idle cycle.
- Clear, then accumulate op_a=0x40 three times:
  - results 0x40 (ov0), 0x80 (ov1), 0xC0 (ov0).
  - Then clear -> done next cycle, result=0x00.
- Start pulse while busy ignored. ena=0 for 3 cycles mid-RUN -> done delayed by 3 cycles, result unchanged. rst=1 mid-RUN -> all outputs 0 next cycle, acc=0.
- WIDTH=16: add 0xFFFF+0x0001 -> result=0x0000, carry_out=1, done 16 clocks after start.
